// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: scan FSM states and active-low {g,f,e,d,c,b,a} segment patterns
package seg_scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low 7-segment pattern, non-BCD shows a dash
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with per-slot dead time.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking on digits 3..1.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int DP_DIGIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] digits_i,
  input  logic        hold_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);
  localparam int PW = $clog2(TICK_DIV);
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d, dec;
  logic [3:0]    an_q, an_d, nib;
  logic          dp_q, dp_d, frame_q, frame_d;
  logic          slot_end, start, show, blank_lz;

  assign slot_end = presc_q == PW'(TICK_DIV - 1);
  assign start    = enable && (state_q == IDLE || (slot_end && idx_q == 2'd3));
  assign nib      = shadow_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_dec (.bcd_i(nib), .seg_o(dec));

`ifdef SEG_SCAN_LZB_EN
  logic [3:0] lit;
  // a digit stays lit once it or any higher digit is non-zero
  assign lit      = {|shadow_q[15:12], |shadow_q[15:8], |shadow_q[15:4], 1'b1};
  assign blank_lz = ~lit[idx_q];
`else
  assign blank_lz = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (!enable) begin
      state_d = IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      presc_d  = (state_q == IDLE || slot_end) ? '0 : presc_q + 1'b1;
      idx_d    = state_q == IDLE ? 2'd0 : idx_q + 2'(slot_end);
      state_d  = presc_d < PW'(BLANK_CYC) ? BLANK : SHOW;
      shadow_d = (start && !hold_i) ? digits_i : shadow_q;
    end
    show    = enable && state_q == SHOW;
    frame_d = start;
    an_d    = show ? ~(4'b1 << idx_q) : 4'hF;
    seg_d   = (!show || blank_lz) ? SEG_OFF : dec;
    dp_d    = !(show && idx_q == 2'(DP_DIGIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= 4'hF;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;
endmodule
